// File: rtl/fifo_sync_prog_if.sv
// Bundle of write-side and read-side signals for fifo_sync_prog.
// Handshake semantics: a write is taken on a rising clk edge when winc && !wfull;
// a read is taken when rinc && !rempty. A request made against the opposite flag
// is dropped and reported by a one-cycle overflow/underflow pulse on the next cycle.
interface fifo_sync_prog_if #(
  parameter int DSIZE = 128,
  parameter int ASIZE = 9
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wdata, winc, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered.
module fifo_sync_prog #(
  parameter int DSIZE      = 128,
  parameter int ASIZE      = 9,
  parameter int AFULL_THR  = 480,
  parameter int AEMPTY_THR = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_sync_prog_if.slave bus
);

  localparam logic [ASIZE:0] DEPTH   = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_THR  = AFULL_THR[ASIZE:0];
  localparam logic [ASIZE:0] AE_THR  = AEMPTY_THR[ASIZE:0];

  logic [DSIZE-1:0] mem [2**ASIZE];
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  // Flags come only from the registered count, so winc/rinc never reach them combinationally.
  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  assign wr_en = bus.winc && !full;
  assign rd_en = bus.rinc && !empty;

  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (count_q >= AF_THR);
  assign bus.ralmost_empty = (count_q <= AE_THR);
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr       <= '0;
      raddr       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.winc && full;
      underflow_q <= bus.rinc && empty;
      if (wr_en) begin
        waddr <= waddr + 1'b1;
      end
      if (rd_en) begin
        raddr <= raddr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; rinc only acknowledges it.
  assign bus.rdata = mem[raddr];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[raddr];
    end
  end

  assign bus.rdata = rdata_q;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: directed test-plan phases plus a long random phase,
// checked against a queue-based occupancy/data model.
module tb_fifo_sync_prog;

  localparam int DSIZE = 128;
  localparam int ASIZE = 9;
  localparam int AFT   = 480;
  localparam int AET   = 32;
  localparam int DEPTH = 512;

  logic clk;
  logic rst_n;

  fifo_sync_prog_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  fifo_sync_prog #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_THR(AFT), .AEMPTY_THR(AET)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DSIZE-1:0] exp_q[$];
  logic [DSIZE-1:0] exp_rdata;
  logic             exp_ovf;
  logic             exp_udf;
  int               checks;
  int               failures;

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [ASIZE:0] obs, input logic [ASIZE:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DSIZE-1:0] obs, input logic [DSIZE-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    chk_cnt ({tag, ".count"},         bus.count,         (ASIZE+1)'(n));
    chk_bit ({tag, ".rempty"},        bus.rempty,        n == 0);
    chk_bit ({tag, ".wfull"},         bus.wfull,         n == DEPTH);
    chk_bit ({tag, ".ralmost_empty"}, bus.ralmost_empty, n <= AET);
    chk_bit ({tag, ".walmost_full"},  bus.walmost_full,  n >= AFT);
    chk_bit ({tag, ".overflow"},      bus.overflow,      exp_ovf);
    chk_bit ({tag, ".underflow"},     bus.underflow,     exp_udf);
`ifdef FIFO_FWFT_EN
    if (n != 0) chk_data({tag, ".rdata"}, bus.rdata, exp_q[0]);
`else
    chk_data({tag, ".rdata"}, bus.rdata, exp_rdata);
`endif
  endtask

  // driver: one clock cycle of requests, then model update and full output check
  task automatic cycle(input string tag, input logic w, input logic r, input logic [DSIZE-1:0] d);
    bit full;
    bit empty;
    bit wacc;
    bit racc;
    bus.winc  = w;
    bus.rinc  = r;
    bus.wdata = d;
    full  = (exp_q.size() == DEPTH);
    empty = (exp_q.size() == 0);
    wacc  = w && !full;
    racc  = r && !empty;
    @(posedge clk);
    #1;
    if (racc) exp_rdata = exp_q.pop_front();
    if (wacc) exp_q.push_back(d);
    exp_ovf = w && full;
    exp_udf = r && empty;
    check_outputs(tag);
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
  endtask

  function automatic logic [DSIZE-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DSIZE-1:0] word_cnt;
    int bias;
    checks    = 0;
    failures  = 0;
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    word_cnt  = '0;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;

    // power-on reset
    rst_n = 1'b0;
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("idle", 1'b0, 1'b0, '0);

    // fill with 0..511, then one rejected write
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, DSIZE'(i));
    cycle("fill_ovf", 1'b1, 1'b0, '1);
    cycle("fill_after", 1'b0, 1'b0, '0);

    // drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, '0);
    chk_data("drain_last", exp_rdata, DSIZE'(DEPTH - 1));
    cycle("drain_udf", 1'b0, 1'b1, '0);
    cycle("drain_after", 1'b0, 1'b0, '0);

    // wrap-around across the 512 boundary
    for (int i = 0; i < 400; i++) cycle("wrap_w1", 1'b1, 1'b0, DSIZE'(1000 + i));
    for (int i = 0; i < 400; i++) cycle("wrap_r1", 1'b0, 1'b1, '0);
    for (int i = 0; i < 300; i++) cycle("wrap_w2", 1'b1, 1'b0, DSIZE'(2000 + i));
    for (int i = 0; i < 300; i++) cycle("wrap_r2", 1'b0, 1'b1, '0);
    chk_data("wrap_last", exp_rdata, DSIZE'(2299));

    // simultaneous requests at full
    for (int i = 0; i < DEPTH; i++) cycle("sim_fill", 1'b1, 1'b0, rand_word());
    cycle("sim_full", 1'b1, 1'b1, rand_word());
    chk_cnt("sim_full_cnt", bus.count, (ASIZE+1)'(DEPTH - 1));
    chk_bit("sim_full_ovf", bus.overflow, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cycle("sim_drain", 1'b0, 1'b1, '0);

    // simultaneous requests at empty
    cycle("sim_empty", 1'b1, 1'b1, rand_word());
    chk_cnt("sim_empty_cnt", bus.count, (ASIZE+1)'(1));
    chk_bit("sim_empty_udf", bus.underflow, 1'b1);

    // steady state at count 100
    for (int i = 0; i < 99; i++) cycle("sim_up", 1'b1, 1'b0, rand_word());
    for (int i = 0; i < 50; i++) cycle("sim_100", 1'b1, 1'b1, rand_word());
    chk_cnt("sim_100_cnt", bus.count, (ASIZE+1)'(100));
    for (int i = 0; i < 100; i++) cycle("sim_down", 1'b0, 1'b1, '0);

    // asynchronous reset mid-burst at count 200
    for (int i = 0; i < 200; i++) cycle("pre_rst", 1'b1, 1'b0, rand_word());
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    check_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle("post_rst_w", 1'b1, 1'b0, DSIZE'(3000 + i));
    cycle("post_rst_r", 1'b0, 1'b1, '0);
    chk_data("post_rst_first", exp_rdata, DSIZE'(3000));
    for (int i = 0; i < 4; i++) cycle("post_rst_r", 1'b0, 1'b1, '0);

    // random back-to-back traffic with stalls and shifting bias
    bias = 2;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0) bias = $urandom_range(1, 3);
      word_cnt = word_cnt + 1'b1;
      cycle("random", $urandom_range(0, 3) < bias, $urandom_range(0, 3) < (4 - bias), word_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
